fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_skid_buf.sv | 33 +++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  localparam word_t HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry (instr, pc) holding register that catches a fetch returning while decode stalls.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  drain,
  input  logic  clear,
  input  word_t load_instr,
  input  word_t load_pc,
  output logic  valid,
  output word_t instr,
  output word_t pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, one outstanding read, skid buffer and IF/ID register.
module fetch_unit
  import fetch_pkg::word_t;
  import fetch_pkg::fetch_state_e;
  import fetch_pkg::RUN;
  import fetch_pkg::HALT;
#(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] HALT_WORD = fetch_pkg::HALT_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic [31:0] instr_in,
  input  logic        id_stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] ifaddress,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  fetch_state_e state, state_next;

  word_t pc;
  logic  inflight_valid;
  word_t inflight_pc;

  logic  skid_valid;
  word_t skid_instr;
  word_t skid_pc;

  logic take_skid, halt_hit, deliver, skid_load, skid_full_next, ifid_load;
  logic run_state, issue;

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (branch_taken)  state_next = RUN;
    else if (halt_hit) state_next = HALT;
  end

  always_comb begin
    run_state = (state == RUN);
    halted    = (state == HALT);
  end

  // Priority: redirect, then skid drain, then halt detection, then delivery of the inflight read.
  always_comb begin
    take_skid      = !branch_taken && skid_valid && !id_stall;
    halt_hit       = !branch_taken && !take_skid && inflight_valid && (instr_in == HALT_WORD);
    deliver        = !branch_taken && !take_skid && inflight_valid && !halt_hit;
    skid_load      = deliver && id_stall;
    skid_full_next = !branch_taken && ((skid_valid && id_stall) || skid_load);
    ifid_load      = take_skid || (deliver && !id_stall);
    issue          = run_state && fetch_en && !branch_taken && !skid_full_next && !halt_hit;
  end

  fetch_skid_buf u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .drain      (take_skid),
    .clear      (branch_taken),
    .load_instr (instr_in),
    .load_pc    (inflight_pc),
    .valid      (skid_valid),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc             <= RESET_PC;
      inflight_valid <= 1'b0;
      inflight_pc    <= '0;
      if_instr       <= '0;
      if_pc          <= '0;
      if_valid       <= 1'b0;
      fetch_count    <= '0;
    end else begin
      inflight_valid <= issue;
      if (issue) inflight_pc <= pc;
      if (branch_taken) begin
        pc       <= branch_target;
        if_valid <= 1'b0;
      end else begin
        if (issue) pc <= pc + 32'd1;
        if (ifid_load) begin
          if_instr    <= take_skid ? skid_instr : instr_in;
          if_pc       <= take_skid ? skid_pc : inflight_pc;
          if_valid    <= 1'b1;
          fetch_count <= fetch_count + 32'd1;
        end else if (!id_stall) begin
          if_valid <= 1'b0;
        end
      end
    end
  end

  assign ifaddress = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected IF/ID loads are queued with stimulus and popped on each load.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [31:0] instr_in;
  logic        id_stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] ifaddress;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        halted;
  logic [31:0] fetch_count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [64];
  logic [31:0] prev_count = '0;
  int          total = 0;
  int          bad = 0;

  fetch_unit #(.RESET_PC(32'd0), .HALT_WORD(32'hFFFF_FFFF)) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_en      (fetch_en),
    .instr_in      (instr_in),
    .id_stall      (id_stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .ifaddress     (ifaddress),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_valid      (if_valid),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  // Registered instruction memory, one cycle of latency.
  always @(posedge clk) instr_in <= mem[ifaddress[5:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Every fetch_count step is an IF/ID load; a drop to zero is a reset.
  always @(negedge clk) begin
    if (fetch_count != prev_count) begin
      if (fetch_count != 32'd0) begin
        exp_t e;
        e = (sb.size() > 0) ? sb.pop_front() : '{pc: '1, instr: '1};
        chk("sb_pc", if_pc, e.pc);
        chk("sb_instr", if_instr, e.instr);
        chk("sb_valid", {31'd0, if_valid}, 32'd1);
        chk("sb_count", fetch_count, prev_count + 32'd1);
      end
      prev_count = fetch_count;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input int first, input int last);
    for (int p = first; p <= last; p++) sb.push_back('{pc: 32'(p), instr: 32'(p + 100)});
  endtask

  task automatic check_reset();
    chk("rst_addr", ifaddress, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fetch_en = 1'b0;
    id_stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    tick();
    check_reset();
    rst = 1'b0;
  endtask

  task automatic wait_ifpc(input logic [31:0] p);
    int n = 0;
    while (!(if_valid && if_pc == p) && n < 100) begin tick(); n++; end
    chk("wait_ifpc", if_pc, p);
  endtask

  task automatic run_until_addr(input logic [31:0] a);
    int n = 0;
    while (ifaddress != a && n < 100) begin tick(); n++; end
    chk("run_addr", ifaddress, a);
  endtask

  task automatic wait_halted();
    int n = 0;
    while (!halted && n < 100) begin tick(); n++; end
    chk("wait_halt", {31'd0, halted}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    fetch_en = 1'b0;
    while (sb.size() != 0 && n < 100) begin tick(); n++; end
    chk("drain_left", 32'(sb.size()), 32'd0);
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_addr;
    for (int i = 0; i < 64; i++) mem[i] = 32'(i + 100);
    rst = 1'b1;
    fetch_en = 1'b0;
    id_stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;

    // Streaming fetch with no stalls
    do_reset();
    push_seq(0, 5);
    fetch_en = 1'b1;
    tick();
    chk("t1_addr1", ifaddress, 32'd1);
    chk("t1_novalid", {31'd0, if_valid}, 32'd0);
    tick();
    chk("t1_valid", {31'd0, if_valid}, 32'd1);
    chk("t1_pc0", if_pc, 32'd0);
    chk("t1_instr0", if_instr, 32'd100);
    chk("t1_cnt1", fetch_count, 32'd1);
    run_until_addr(32'd6);
    drain();
    chk("t1_cnt", fetch_count, 32'd6);
    chk("t1_addr", ifaddress, 32'd6);
    chk("t1_idle", {31'd0, if_valid}, 32'd0);

    // Decode stall for three cycles with pc 3 caught in the skid
    do_reset();
    push_seq(0, 9);
    fetch_en = 1'b1;
    wait_ifpc(32'd2);
    id_stall = 1'b1;
    repeat (3) begin
      tick();
      chk("t2_hold_pc", if_pc, 32'd2);
      chk("t2_hold_valid", {31'd0, if_valid}, 32'd1);
    end
    chk("t2_addr_frozen", ifaddress, 32'd4);
    id_stall = 1'b0;
    tick();
    chk("t2_release_pc", if_pc, 32'd3);
    chk("t2_release_addr", ifaddress, 32'd5);
    run_until_addr(32'd10);
    drain();
    chk("t2_cnt", fetch_count, 32'd10);

    // Redirect while pc 5 is inflight
    do_reset();
    push_seq(0, 4);
    push_seq(8, 10);
    fetch_en = 1'b1;
    run_until_addr(32'd6);
    branch_taken = 1'b1;
    branch_target = 32'd8;
    tick();
    chk("t3_flush_valid", {31'd0, if_valid}, 32'd0);
    chk("t3_target", ifaddress, 32'd8);
    branch_taken = 1'b0;
    run_until_addr(32'd11);
    drain();
    chk("t3_cnt", fetch_count, 32'd8);

    // Halt word at address 4, then branch back to 0 and halt again
    mem[4] = 32'hFFFF_FFFF;
    do_reset();
    push_seq(0, 3);
    fetch_en = 1'b1;
    wait_halted();
    chk("t4_addr", ifaddress, 32'd5);
    chk("t4_cnt", fetch_count, 32'd4);
    chk("t4_valid", {31'd0, if_valid}, 32'd0);
    repeat (3) tick();
    chk("t4_frozen", ifaddress, 32'd5);
    chk("t4_still_halt", {31'd0, halted}, 32'd1);
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);
    push_seq(0, 3);
    branch_taken = 1'b1;
    branch_target = 32'd0;
    tick();
    chk("t4_unhalt", {31'd0, halted}, 32'd0);
    chk("t4_redirect", ifaddress, 32'd0);
    branch_taken = 1'b0;
    wait_halted();
    chk("t4_cnt2", fetch_count, 32'd8);
    chk("t4_addr2", ifaddress, 32'd5);
    mem[4] = 32'd104;
    drain();

    // Reset while stalled with the skid full
    do_reset();
    push_seq(0, 2);
    fetch_en = 1'b1;
    wait_ifpc(32'd2);
    id_stall = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check_reset();
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);
    rst = 1'b0;
    id_stall = 1'b0;
    push_seq(0, 2);
    tick();
    chk("t5_restart", ifaddress, 32'd1);
    run_until_addr(32'd3);
    drain();
    chk("t5_cnt", fetch_count, 32'd3);

    // fetch_en toggling
    do_reset();
    push_seq(0, 3);
    exp_addr = '0;
    for (int i = 0; i < 8; i++) begin
      fetch_en = (i % 2 == 0);
      exp_addr = exp_addr + {31'd0, fetch_en};
      tick();
      chk("t6_addr", ifaddress, exp_addr);
    end
    drain();
    chk("t6_cnt", fetch_count, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
